// File: rtl/upsample_window.sv
// Zero-stuffing upsampler feeding a 7-tap delay line; each shift position is offered once
// over a taps_valid/out_ready handshake.
module upsample_window #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned L          = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  taps_valid,
  output logic [DATA_WIDTH+1:0] tap0,
  output logic [DATA_WIDTH+1:0] tap1,
  output logic [DATA_WIDTH+1:0] tap2,
  output logic [DATA_WIDTH+1:0] tap3,
  output logic [DATA_WIDTH+1:0] tap4,
  output logic [DATA_WIDTH+1:0] tap5,
  output logic [DATA_WIDTH+1:0] tap6,
  output logic [2:0]            phase
);

  localparam int unsigned TW      = DATA_WIDTH + 2;
  localparam logic [3:0]  LFact   = 4'(L);
  localparam logic [2:0]  CntInit = 3'(L - 1);

  typedef enum logic [0:0] {StSample, StStuff} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      phase_q, phase_d;
  logic            taps_valid_q, taps_valid_d;
  logic [TW-1:0]   line_q [7];
  logic [TW-1:0]   line_d [7];
  logic            can_push;
  logic            push;
  logic [TW-1:0]   push_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StSample;
      cnt_q        <= '0;
      phase_q      <= '0;
      taps_valid_q <= 1'b0;
      for (int k = 0; k < 7; k++) line_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      taps_valid_q <= taps_valid_d;
      for (int k = 0; k < 7; k++) line_q[k] <= line_d[k];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    taps_valid_d = taps_valid_q;
    line_d       = line_q;
    if (flush) begin
      state_d      = StSample;
      cnt_d        = '0;
      phase_d      = '0;
      taps_valid_d = 1'b0;
      for (int k = 0; k < 7; k++) line_d[k] = '0;
    end else if (push) begin
      line_d[0] = push_val;
      for (int k = 1; k < 7; k++) line_d[k] = line_q[k-1];
      taps_valid_d = 1'b1;
      if (state_q == StSample) begin
        phase_d = '0;
        if (L > 1) begin
          state_d = StStuff;
          cnt_d   = CntInit;
        end
      end else begin
        phase_d = 3'(LFact - {1'b0, cnt_q});
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = StSample;
      end
    end else if (out_ready) begin
      // Window consumed with nothing new behind it.
      taps_valid_d = 1'b0;
    end
  end

  always_comb begin
    can_push = !taps_valid_q || out_ready;
    in_ready = 1'b0;
    push     = 1'b0;
    push_val = '0;
    if (!flush) begin
      unique case (state_q)
        StSample: begin
          in_ready = can_push;
          push     = in_valid && can_push;
          push_val = {{2{in_data[DATA_WIDTH-1]}}, in_data};
        end
        StStuff: push = can_push;
        default: ;
      endcase
    end
  end

  assign taps_valid = taps_valid_q;
  assign phase      = phase_q;
  assign tap0       = line_q[0];
  assign tap1       = line_q[1];
  assign tap2       = line_q[2];
  assign tap3       = line_q[3];
  assign tap4       = line_q[4];
  assign tap5       = line_q[5];
  assign tap6       = line_q[6];

endmodule

// File: tb/tb_upsample_window.sv
// Scoreboard bench for upsample_window: instances with L = 1, 2 and 4 share one clock and reset.
module tb_upsample_window;

  localparam int N = 3;

  typedef struct packed {
    logic [2:0]       ph;
    logic [6:0][9:0]  t;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush [N];
  logic       in_valid [N];
  logic       in_ready [N];
  logic       out_ready [N];
  logic       taps_valid [N];
  logic [7:0] in_data [N];
  logic [9:0] tap [N][7];
  logic [2:0] phase [N];

  int n_tests = 0;
  int n_fail  = 0;

  win_t q0[$];
  win_t q1[$];
  win_t q2[$];
  logic [6:0][9:0] mdl [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned LG = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    upsample_window #(.DATA_WIDTH(8), .L(LG)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush[g]),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .out_ready  (out_ready[g]),
      .taps_valid (taps_valid[g]),
      .tap0       (tap[g][0]),
      .tap1       (tap[g][1]),
      .tap2       (tap[g][2]),
      .tap3       (tap[g][3]),
      .tap4       (tap[g][4]),
      .tap5       (tap[g][5]),
      .tap6       (tap[g][6]),
      .phase      (phase[g])
    );
  end

  function automatic logic [9:0] s10(input int v);
    return v[9:0];
  endfunction

  function automatic logic [9:0] sx(input logic [7:0] d);
    return {{2{d[7]}}, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected window after one push of v with the given phase.
  task automatic model_push(input int i, input logic [9:0] v, input logic [2:0] ph);
    win_t w;
    mdl[i] = {mdl[i][5:0], v};
    w.ph   = ph;
    w.t    = mdl[i];
    case (i)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic pop_check(input int i);
    win_t e;
    win_t got;
    bit   empty;
    got.ph = phase[i];
    for (int k = 0; k < 7; k++) got.t[k] = tap[i][k];
    case (i)
      0:       empty = (q0.size() == 0);
      1:       empty = (q1.size() == 0);
      default: empty = (q2.size() == 0);
    endcase
    e = '0;
    if (!empty) begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
    n_tests++;
    if (empty) begin
      n_fail++;
      $display("FAIL window%0d: got phase=%0d taps=%h, required no window", i, got.ph, got.t);
    end else if (got !== e) begin
      n_fail++;
      $display("FAIL window%0d: got phase=%0d taps=%h, required phase=%0d taps=%h",
               i, got.ph, got.t, e.ph, e.t);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (taps_valid[i] && out_ready[i]) pop_check(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] samp [3];
    logic [7:0] fl [8];
    int cyc;

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      flush[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      in_data[i]   = '0;
      mdl[i]       = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_in_ready", in_ready[i], 1);
      chk("rst_taps_valid", taps_valid[i], 0);
      chk("rst_tap0", tap[i][0], 0);
      chk("rst_phase", phase[i], 0);
    end
    step();

    // Stuffing, L=2
    samp = '{8'd232, 8'd142, 8'd17};
    in_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data[1] = samp[c/2];
      if (c % 2 == 0) model_push(1, sx(samp[c/2]), 3'd0);
      else            model_push(1, 10'd0, 3'd1);
      @(negedge clk);
      chk("l2_in_ready", in_ready[1], (c % 2 == 0) ? 1 : 0);
      step();
    end
    in_valid[1] = 1'b0;
    model_push(1, 10'd0, 3'd1);
    chk("l2_tap0", tap[1][0], s10(17));
    chk("l2_tap1", tap[1][1], 0);
    chk("l2_tap2", tap[1][2], s10(-114));
    chk("l2_tap3", tap[1][3], 0);
    chk("l2_tap4", tap[1][4], s10(-24));
    chk("l2_tap0_hex", tap[1][0], 10'h011);
    repeat (4) step();

    // Backpressure, L=2
    in_valid[1] = 1'b1;
    in_data[1]  = 8'd54;
    model_push(1, sx(8'd54), 3'd0);
    step();
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_tap0", tap[1][0], 54);
      chk("bp_phase", phase[1], 0);
      chk("bp_in_ready", in_ready[1], 0);
      chk("bp_taps_valid", taps_valid[1], 1);
      step();
    end
    out_ready[1] = 1'b1;
    model_push(1, 10'd0, 3'd1);
    step();
    chk("bp_resume_tap0", tap[1][0], 0);
    chk("bp_resume_phase", phase[1], 1);
    repeat (3) step();

    // Full line, L=1
    fl = '{8'd232, 8'd142, 8'd17, 8'd54, 8'd251, 8'd30, 8'd16, 8'd5};
    in_valid[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data[0] = fl[c];
      model_push(0, sx(fl[c]), 3'd0);
      @(negedge clk);
      chk("l1_in_ready", in_ready[0], 1);
      step();
      if (c == 6) begin
        chk("l1_full_tap0", tap[0][0], s10(16));
        chk("l1_full_tap1", tap[0][1], s10(30));
        chk("l1_full_tap2", tap[0][2], s10(-5));
        chk("l1_full_tap3", tap[0][3], s10(54));
        chk("l1_full_tap4", tap[0][4], s10(17));
        chk("l1_full_tap5", tap[0][5], s10(-114));
        chk("l1_full_tap6", tap[0][6], s10(-24));
      end
    end
    in_valid[0] = 1'b0;
    chk("l1_shift_tap6", tap[0][6], s10(-114));
    chk("l1_shift_tap0", tap[0][0], s10(5));
    repeat (3) step();

    // Flush mid-STUFF, L=4
    in_valid[2] = 1'b1;
    in_data[2]  = 8'd54;
    model_push(2, sx(8'd54), 3'd0);
    step();
    in_valid[2] = 1'b0;
    model_push(2, 10'd0, 3'd1);
    step();
    model_push(2, 10'd0, 3'd2);
    step();
    chk("fl_phase2", phase[2], 2);
    flush[2]    = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2]  = 8'd99;
    @(negedge clk);
    chk("fl_in_ready", in_ready[2], 0);
    step();
    flush[2]    = 1'b0;
    in_valid[2] = 1'b0;
    mdl[2]      = '0;
    for (int k = 0; k < 7; k++) chk("fl_tap_zero", tap[2][k], 0);
    chk("fl_taps_valid", taps_valid[2], 0);
    chk("fl_phase", phase[2], 0);
    @(negedge clk);
    chk("fl_sample_ready", in_ready[2], 1);
    step();
    chk("fl_no_stuff", taps_valid[2], 0);
    flush[2]    = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2]  = 8'd77;
    @(negedge clk);
    chk("fl_idle_in_ready", in_ready[2], 0);
    step();
    flush[2]    = 1'b0;
    in_valid[2] = 1'b0;
    chk("fl_idle_taps_valid", taps_valid[2], 0);
    chk("fl_idle_tap0", tap[2][0], 0);
    step();

    // Phase sequence, L=4
    in_valid[2] = 1'b1;
    in_data[2]  = 8'd30;
    model_push(2, sx(8'd30), 3'd0);
    model_push(2, 10'd0, 3'd1);
    model_push(2, 10'd0, 3'd2);
    model_push(2, 10'd0, 3'd3);
    @(negedge clk);
    chk("ph_in_ready0", in_ready[2], 1);
    step();
    in_valid[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ph_stuff_in_ready", in_ready[2], 0);
      step();
    end
    chk("ph_tap3", tap[2][3], s10(30));
    chk("ph_tap2", tap[2][2], 0);
    chk("ph_tap1", tap[2][1], 0);
    chk("ph_tap0", tap[2][0], 0);
    chk("ph_phase", phase[2], 3);
    repeat (3) step();

    // Reset mid-STUFF, L=2
    in_valid[1] = 1'b1;
    in_data[1]  = 8'd100;
    model_push(1, sx(8'd100), 3'd0);
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < N; i++) mdl[i] = '0;
    for (int k = 0; k < 7; k++) chk("rs_tap_zero", tap[1][k], 0);
    chk("rs_taps_valid", taps_valid[1], 0);
    chk("rs_phase", phase[1], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rs_in_ready", in_ready[1], 1);
    chk("rs_taps_valid_rel", taps_valid[1], 0);
    step();
    chk("rs_stuff_dropped", taps_valid[1], 0);

    cyc = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/upsample_window.md
# upsample_window

Upstream feeder for `filtroup`: accepts signed input samples over a valid/ready handshake and zero-stuffs them by factor L (upsampling). It maintains a 7-entry tap delay line and presents the taps, sign-extended to DATA_WIDTH+2 bits, on `tap0..tap6`. Those outputs drive `filtroup` `in0..in6` directly. A `taps_valid`/`out_ready` handshake paces the line so that each shift position is consumed exactly once.

## Interface
- DATA_WIDTH, 8, width of the signed input sample; taps are DATA_WIDTH+2 bits wide.
- L, 2, upsampling factor, legal range 1..8. With L=1 no zeros are inserted.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the delay line and FSM.
- in_data  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle (combinational).
- out_ready  in  1  downstream consumes the current taps this cycle.
- taps_valid  out  1  tap0..tap6 hold a new, unconsumed window.
- tap0..tap6  out  DATA_WIDTH+2 each  signed delay line; tap0 is the newest entry, tap6 the oldest.
- phase  out  3  phase of the entry on tap0: 0 = real sample, 1..L-1 = stuffed zero.

## Operation
- can_push = !taps_valid || out_ready.
- A push is one delay-line shift. tap0 receives the new value, and tap(k) receives tap(k-1) for k=1..6. The previous tap6 is discarded.
- FSM states:
  - SAMPLE: in_ready = can_push.
    - On in_valid && can_push, push sign-extended in_data and set phase=0.
    - If L>1, go to STUFF with cnt=L-1.
  - STUFF: in_ready = 0.
    - On can_push, push 0, set phase = L-cnt, and decrement cnt.
    - When the push is made with cnt==1, return to SAMPLE.
    - If can_push=0, hold all state.
- taps_valid update:
  - Set to 1 on any push.
  - Cleared to 0 on out_ready && taps_valid with no push in the same cycle.
  - If a push coincides with consumption, it stays 1, giving continuous streaming.
- Sign extension: replicate in_data[DATA_WIDTH-1] into bits DATA_WIDTH+1:DATA_WIDTH. No gain scaling is applied; L-gain compensation belongs to the filter coefficients.
- The line starts zero-filled, so the first window is valid after the first push. Nothing is suppressed during fill.
- flush (higher priority than push):
  - All taps go to 0, taps_valid=0, phase=0, state=SAMPLE, cnt=0.
  - in_ready is 0 in the flush cycle.
  - An in_valid presented during flush is not accepted.
- Reset values (async, on rst_n low): tap0..tap6=0, taps_valid=0, phase=0, state=SAMPLE, cnt=0. in_ready is 1 after reset release, since taps_valid=0.

## Timing
- Latency: a sample accepted at edge k is on tap0 with taps_valid=1 immediately after edge k. It reaches tap6 after six further pushes.
- Throughput with out_ready held at 1: one push per cycle; one input sample per L cycles. in_ready is high 1 of every L cycles.
- in_ready depends combinationally on out_ready and taps_valid. There is no combinational path from in_valid to in_ready.
- Backpressure: with taps_valid=1 and out_ready=0, taps, phase, cnt and state are frozen indefinitely.
- Reset asserted mid-STUFF: outputs clear immediately (asynchronously). Pending zero pushes are dropped.
- With L=1, STUFF is never entered.

## Test plan
- **Reset:** assert rst_n=0 mid-stream, then release.
  - Immediately on assertion: all taps 0, taps_valid=0, phase=0.
  - After release, at the first clock: in_ready=1.
- **Stuffing, L=2:** out_ready=1, in_valid=1 with data 232, 142, 17 (8-bit, i.e. -24, -114, 17).
  - in_ready sequence 1,0,1,0,1.
  - tap0 sequence -24, 0, -114, 0, 17; phase sequence 0,1,0,1,0.
  - After the 5th push, tap0..tap4 = 17, 0, -114, 0, -24, and tap0 = 10'h011.
- **Backpressure:** L=2. Push 54 so that taps_valid=1, then hold out_ready=0 for 3 cycles.
  - tap0 stays 54, phase stays 0, in_ready=0 throughout.
  - After out_ready returns to 1, the next cycle pushes 0 with phase=1.
- **Full line, L=1:** push 232, 142, 17, 54, 251, 30, 16, then one more sample 5.
  - After 7 pushes: tap0..tap6 = 16, 30, -5, 54, 17, -114, -24.
  - After the push of 5: -24 is discarded and tap6 = -114.
- **Flush mid-STUFF:** L=4, push 54, then assert flush during phase 2.
  - Next cycle: all taps 0, taps_valid=0, state SAMPLE.
  - An in_valid sample presented in the flush cycle is not accepted.
- **Phase sequence, L=4:** out_ready=1, feed one sample of 30.
  - Four pushes with phase 0,1,2,3 and in_ready=0 for 3 cycles.
  - Afterwards tap3 = 30 and tap0..tap2 = 0.
